// File: rtl/vga_fb_scan_ctrl_if.sv
// Frame-buffer BRAM port-B bus between the scan-out controller (master) and the memory (slave).
interface vga_fb_scan_ctrl_if;
    logic        enb;
    logic        web;
    logic [18:0] addrb;
    logic [7:0]  doutb;

    modport master (output enb, output web, output addrb, input doutb);
    modport slave  (input enb, input web, input addrb, output doutb);
endinterface

// File: rtl/vga_fb_scan_ctrl.sv
// VGA scan-out controller: raster timing, frame-buffer port-B reads and RGB332 to 4:4:4 expansion.
// Display starts on a frame boundary once the writer has reported a complete frame.
module vga_fb_scan_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int RD_LAT   = 1,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_ready_i,
    vga_fb_scan_ctrl_if.master bram,
    output logic               frame_start_o,
    output logic               vga_hs_o,
    output logic               vga_vs_o,
    output logic [3:0]         vga_r_o,
    output logic [3:0]         vga_g_o,
    output logic [3:0]         vga_b_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE   = DW'(CLK_DIV - 2);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0]   ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

    logic [DW-1:0]     div_cnt_q, div_cnt_d;
    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic [18:0]       addr_cnt_q;
    logic [18:0]       addrb_q;
    state_t            state_q;
    logic              ready_q;
    logic              enb_q;
    logic              frame_start_q;
    logic              tick_s, pre_tick_s, boundary_s, origin_s;
    logic              active_s, hs_raw_s, vs_raw_s, read_s;
    logic [RD_LAT-1:0] vld_q, hs_p_q, vs_p_q, act_p_q, show_p_q;
    logic              hs_q, vs_q;
    logic [11:0]       rgb_q;

    function automatic logic [11:0] rgb332_to_444(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    // Raster position decode and counter next-state.
    always_comb begin
        tick_s     = (div_cnt_q == DIV_LAST);
        pre_tick_s = (div_cnt_q == DIV_PRE);
        active_s   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_raw_s   = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vs_raw_s   = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        origin_s   = (h_cnt_q == '0) && (v_cnt_q == '0);
        boundary_s = tick_s && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        read_s     = active_s && (state_q == ST_SHOW);
        div_cnt_d  = tick_s ? '0 : div_cnt_q + DW'(1);
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        if (tick_s) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q;
        end
    end

    // Pixel divider and raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    // Display FSM, read issue and address generation. Strobes are set one cycle
    // early (pre_tick) so they are high exactly during the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            ready_q       <= 1'b0;
            addr_cnt_q    <= 19'd0;
            addrb_q       <= 19'd0;
            enb_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pre_tick_s && origin_s;
            enb_q         <= pre_tick_s && read_s;
            if (pre_tick_s && read_s) begin
                addrb_q <= addr_cnt_q;
            end
            if (boundary_s) begin
                addr_cnt_q <= 19'd0;
            end else if (tick_s && read_s) begin
                addr_cnt_q <= (addr_cnt_q == ADDR_LAST) ? 19'd0 : addr_cnt_q + 19'd1;
            end
            case (state_q)
                ST_BLANK: begin
                    if (boundary_s && (ready_q || frame_ready_i)) begin
                        state_q <= ST_SHOW;
                        ready_q <= 1'b0;
                    end else if (frame_ready_i) begin
                        ready_q <= 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (frame_ready_i) begin
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_BLANK;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Carry per-pixel timing flags until the matching read data returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            hs_p_q   <= '1;
            vs_p_q   <= '1;
            act_p_q  <= '0;
            show_p_q <= '0;
        end else begin
            vld_q[0] <= tick_s;
            if (tick_s) begin
                hs_p_q[0]   <= hs_raw_s;
                vs_p_q[0]   <= vs_raw_s;
                act_p_q[0]  <= active_s;
                show_p_q[0] <= (state_q == ST_SHOW);
            end
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k]    <= vld_q[k-1];
                hs_p_q[k]   <= hs_p_q[k-1];
                vs_p_q[k]   <= vs_p_q[k-1];
                act_p_q[k]  <= act_p_q[k-1];
                show_p_q[k] <= show_p_q[k-1];
            end
        end
    end

    // VGA output registers, updated once per pixel when its data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= 12'h000;
        end else if (vld_q[RD_LAT-1]) begin
            hs_q  <= hs_p_q[RD_LAT-1];
            vs_q  <= vs_p_q[RD_LAT-1];
            rgb_q <= (act_p_q[RD_LAT-1] && show_p_q[RD_LAT-1]) ?
                     rgb332_to_444(bram.doutb) : 12'h000;
        end
    end

    assign bram.enb      = enb_q;
    assign bram.web      = 1'b0;
    assign bram.addrb    = addrb_q;
    assign frame_start_o = frame_start_q;
    assign vga_hs_o      = hs_q;
    assign vga_vs_o      = vs_q;
    assign vga_r_o       = rgb_q[11:8];
    assign vga_g_o       = rgb_q[7:4];
    assign vga_b_o       = rgb_q[3:0];
endmodule

// File: tb/tb_vga_fb_scan_ctrl.sv
// Bench for vga_fb_scan_ctrl on a reduced raster; outputs are compared every cycle
// against a timeline model computed from cycle counts since reset release.
module tb_vga_fb_scan_ctrl;
    localparam int CD  = 4;
    localparam int RL  = 1;
    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 2;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FT  = HT * VT;
    localparam int FC  = FT * CD;
    localparam int NPIX = HA * VA;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_ready_i = 1'b0;
    logic       frame_start_o, vga_hs_o, vga_vs_o;
    logic [3:0] vga_r_o, vga_g_o, vga_b_o;

    vga_fb_scan_ctrl_if bus();

    vga_fb_scan_ctrl #(
        .CLK_DIV(CD), .RD_LAT(RL),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_ready_i(frame_ready_i), .bram(bus),
        .frame_start_o(frame_start_o), .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o),
        .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:NPIX-1];

    // One-cycle-latency port-B memory model.
    always @(posedge clk) begin
        if (!rst_n) bus.doutb <= 8'h00;
        else if (bus.enb) bus.doutb <= (bus.addrb < 19'(NPIX)) ? mem[int'(bus.addrb)] : 8'h00;
    end

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    longint ready_cyc = -1;
    longint exp_addr = 0;
    int     enb_cnt = 0;
    logic [18:0] last_addr_seen = 19'd0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    // A frame displays when the first ready pulse came no later than its opening boundary tick.
    function automatic logic shows(input longint f);
        return (f >= 1) && (ready_cyc >= 0) && (f * FC - 1 >= ready_cyc);
    endfunction

    function automatic logic [11:0] expand(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    task automatic check_cycle();
        longint p, h, v, f;
        logic e_fs, e_enb, e_hs, e_vs;
        logic [11:0] e_rgb;
        e_fs = 1'b0; e_enb = 1'b0;
        if (cyc % CD == CD - 1) begin
            p = cyc / CD; h = p % HT; v = (p / HT) % VT; f = p / FT;
            e_fs  = (p % FT == 0);
            e_enb = shows(f) && (h < HA) && (v < VA);
            if (e_enb) exp_addr = v * HA + h;
        end
        e_hs = 1'b1; e_vs = 1'b1; e_rgb = 12'h000;
        if (cyc >= RL + CD) begin
            p = (cyc - RL - CD) / CD; h = p % HT; v = (p / HT) % VT; f = p / FT;
            e_hs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
            e_vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
            if (shows(f) && (h < HA) && (v < VA)) e_rgb = expand(mem[int'(v * HA + h)]);
        end
        chk_eq("frame_start", 32'(frame_start_o), 32'(e_fs));
        chk_eq("enb", 32'(bus.enb), 32'(e_enb));
        chk_eq("web", 32'(bus.web), 32'(1'b0));
        chk_eq("addrb", 32'(bus.addrb), 32'(exp_addr));
        chk_eq("hs", 32'(vga_hs_o), 32'(e_hs));
        chk_eq("vs", 32'(vga_vs_o), 32'(e_vs));
        chk_eq("rgb", 32'({vga_r_o, vga_g_o, vga_b_o}), 32'(e_rgb));
        if (bus.enb) begin
            enb_cnt++;
            last_addr_seen = bus.addrb;
        end
        if (cyc % FC == FC - 1) begin
            f = cyc / FC;
            chk_eq("reads_per_frame", 32'(enb_cnt), shows(f) ? 32'(NPIX) : 32'd0);
            if (shows(f)) chk_eq("last_read_addr", 32'(last_addr_seen), 32'(NPIX - 1));
            enb_cnt = 0;
        end
    endtask

    task automatic run_until(input longint last, input longint pulse_at);
        while (cyc < last) begin
            frame_ready_i = (cyc == pulse_at) || ((ready_cyc >= 0) && ($urandom_range(0, 39) == 0));
            if (frame_ready_i && (ready_cyc < 0)) ready_cyc = cyc;
            @(negedge clk);
            cyc++;
            check_cycle();
        end
        frame_ready_i = 1'b0;
    endtask

    task automatic restart();
        cyc = 0; ready_cyc = -1; exp_addr = 0; enb_cnt = 0;
        frame_ready_i = 1'b0;
        rst_n = 1'b1;
        check_cycle();
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE0; mem[1] = 8'h1C; mem[2] = 8'h03;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        restart();
        // Two idle frames, a ready pulse on line 3 of frame 2, then reset on line 3 of frame 5.
        run_until(longint'(5 * FC + 3 * HT * CD + $urandom_range(0, HT * CD - 1)),
                  longint'(2 * FC + 3 * HT * CD + $urandom_range(0, HT * CD - 1)));
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_enb", 32'(bus.enb), 32'd0);
        chk_eq("rst_addrb", 32'(bus.addrb), 32'd0);
        chk_eq("rst_fs", 32'(frame_start_o), 32'd0);
        chk_eq("rst_hs", 32'(vga_hs_o), 32'd1);
        chk_eq("rst_vs", 32'(vga_vs_o), 32'd1);
        chk_eq("rst_rgb", 32'({vga_r_o, vga_g_o, vga_b_o}), 32'd0);
        repeat (3) @(negedge clk);
        restart();
        // Ready pulse exactly on the boundary tick that opens frame 2.
        run_until(longint'(4 * FC - 1), longint'(2 * FC - 1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
